// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and helpers for the multi-channel clock divider.
//   CNT_W_DEF : default counter/divisor/duty width
//   MIN_DIV   : smallest divisor a configuration write may program
//   ch_w()    : width of the channel-select field for a given channel count
package clk_div_pkg;

  localparam int unsigned CNT_W_DEF = 21;
  localparam int unsigned MIN_DIV   = 2;

  function automatic int unsigned ch_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_if.sv
// clk_div_multi_if: configuration bus of the multi-channel clock divider.
//   cfg_we   : write strobe for one channel's configuration
//   cfg_ch   : target channel of the write
//   cfg_div  : new divisor
//   cfg_duty : new high-count
//   cfg_err  : one-cycle pulse, last write was rejected
// master = configuration source, slave = divider.
interface clk_div_multi_if #(
  parameter int unsigned CH_W  = 2,
  parameter int unsigned CNT_W = 21
);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_duty;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_ch, cfg_div, cfg_duty,
    input  cfg_err
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_div, cfg_duty,
    output cfg_err
  );

endinterface

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel.
//   clk_in, reset : clock, synchronous active-high reset
//   en            : run enable (counter, tick and clk_out freeze when low)
//   sync          : restart counter at 0 and apply any pending shadow
//   wr            : accepted configuration write for this channel
//   wr_div/duty   : values for the shadow registers
//   tick          : one-cycle pulse at the end of each period
//   clk_out       : divided level, high while count < duty
//   pend          : shadow configuration waiting for the period boundary
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DEF_DIV  = 10000,
  parameter int unsigned DEF_DUTY = 5000
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_duty,
  output logic             tick,
  output logic             clk_out,
  output logic             pend
);

  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DEF_DUTY);

  logic [CNT_W-1:0] count, count_nx;
  logic [CNT_W-1:0] div_act, div_nx, duty_act, duty_nx;
  logic [CNT_W-1:0] div_sh, div_sh_nx, duty_sh, duty_sh_nx;
  logic             pend_q, pend_nx;
  logic             tick_q, tick_nx;
  logic             clk_q, clk_nx;
  logic             wrap, apply;

  always_comb begin
    // >= rather than == keeps the counter bounded if an idle-time apply
    // shrinks the divisor below the frozen count.
    wrap  = en && (count >= div_act - CNT_W'(1));
    apply = pend_q && (sync || wrap || !en);

    div_nx  = div_act;
    duty_nx = duty_act;
    if (apply) begin
      div_nx  = div_sh;
      duty_nx = duty_sh;
    end

    count_nx = count;
    if (sync || wrap) count_nx = '0;
    else if (en)      count_nx = count + CNT_W'(1);

    // A write in the apply cycle lands in the shadow after the old shadow
    // has been consumed, so pend stays set for the new value.
    div_sh_nx  = div_sh;
    duty_sh_nx = duty_sh;
    pend_nx    = pend_q;
    if (wr) begin
      div_sh_nx  = wr_div;
      duty_sh_nx = wr_duty;
      pend_nx    = 1'b1;
    end else if (apply) begin
      pend_nx = 1'b0;
    end

    tick_nx = wrap && !sync;

    // Registered from the next count so the level stays aligned with tick.
    clk_nx = clk_q;
    if (sync || en) clk_nx = (count_nx < duty_nx);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      count    <= '0;
      div_act  <= DIV_RST;
      duty_act <= DUTY_RST;
      div_sh   <= DIV_RST;
      duty_sh  <= DUTY_RST;
      pend_q   <= 1'b0;
      tick_q   <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      count    <= count_nx;
      div_act  <= div_nx;
      duty_act <= duty_nx;
      div_sh   <= div_sh_nx;
      duty_sh  <= duty_sh_nx;
      pend_q   <= pend_nx;
      tick_q   <= tick_nx;
      clk_q    <= clk_nx;
    end
  end

  assign tick    = tick_q;
  assign clk_out = clk_q;
  assign pend    = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH independent programmable tick / divided-clock channels.
//   clk_in, reset : clock, synchronous active-high reset
//   cfg           : configuration bus (write strobe, channel, div, duty, err)
//   en            : per-channel run enable
//   sync          : restart all channel counters together
//   tick          : per-channel one-cycle end-of-period pulse
//   clk_out       : per-channel divided level output
//   pend          : per-channel shadow configuration not yet applied
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DEF_DIV  = 10000,
  parameter int unsigned DEF_DUTY = 5000
) (
  input  logic              clk_in,
  input  logic              reset,
  clk_div_multi_if.slave    cfg,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] pend
);

  localparam int unsigned      CH_W     = ch_w(NUM_CH);
  localparam logic [CH_W:0]    CH_LIMIT = (CH_W + 1)'(NUM_CH);
  localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(MIN_DIV);

  logic              cfg_bad;
  logic              err_q;
  logic [NUM_CH-1:0] wr_sel;

  always_comb begin
    cfg_bad = cfg.cfg_we &&
              ((cfg.cfg_div < DIV_MIN) || ({1'b0, cfg.cfg_ch} >= CH_LIMIT));
    wr_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = cfg.cfg_we && !cfg_bad && (32'(cfg.cfg_ch) == i);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= cfg_bad;
  end

  assign cfg.cfg_err = err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_DIV  (DEF_DIV),
      .DEF_DUTY (DEF_DUTY)
    ) u_chan (
      .clk_in  (clk_in),
      .reset   (reset),
      .en      (en[g]),
      .sync    (sync),
      .wr      (wr_sel[g]),
      .wr_div  (cfg.cfg_div),
      .wr_duty (cfg.cfg_duty),
      .tick    (tick[g]),
      .clk_out (clk_out[g]),
      .pend    (pend[g])
    );
  end

endmodule
